// File: rtl/reg_view_ctrl.sv
// reg_view_ctrl: push-button front end for the register-file viewer.
// Debounces three buttons, keeps the viewed register index (manual step or
// auto-scan), reads the register over the debug port and hands the captured
// value to the display over a valid/ready handshake.
module reg_view_ctrl #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int DWELL_CYC    = 100_000_000,
    parameter int REFRESH_CYC  = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_r,
    input  logic        btn_l,
    input  logic        btn_mode,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [31:0] disp_data,
    output logic        disp_valid,
    input  logic        disp_ready,
    output logic [4:0]  leds,
    output logic        auto_mode
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam int DW = $clog2(DWELL_CYC + 1);
    localparam int RW = $clog2(REFRESH_CYC + 1);

    typedef enum logic [1:0] {IDLE, ADDR, CAPT, PRES} state_t;

    // Button lanes: bit 0 = right, bit 1 = left, bit 2 = mode
    logic [2:0]    btn_raw;
    logic [2:0]    sync_a;
    logic [2:0]    sync_b;
    logic [2:0]    level;
    logic [2:0]    level_q;
    logic [2:0]    pulse;
    logic [CW-1:0] deb_cnt [3];

    logic          p_r;
    logic          p_l;
    logic          p_mode;

    logic [4:0]    idx;
    logic [DW-1:0] dwell_cnt;
    logic [RW-1:0] refresh_cnt;
    logic          step_up;
    logic          step_dn;
    logic          dwell_hit;
    logic          refresh_hit;
    logic          idx_change;
    logic          req;
    state_t        state;

    assign btn_raw = {btn_mode, btn_l, btn_r};

    // Two-flop synchronizer bringing the raw buttons into the clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    // Debounce: accept a new level only after it has differed for DEBOUNCE_CYC consecutive cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_b[i] == level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CW'(DEBOUNCE_CYC - 1)) begin
                    deb_cnt[i] <= '0;
                    level[i]   <= ~level[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Delayed copy of the debounced levels for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse  = level & ~level_q;
    assign p_r    = pulse[0];
    assign p_l    = pulse[1];
    assign p_mode = pulse[2];

    // Step decisions: opposing presses cancel, a manual step takes precedence over an auto step
    always_comb begin
        step_up     = p_r & ~p_l;
        step_dn     = p_l & ~p_r;
        dwell_hit   = auto_mode && (dwell_cnt == DW'(DWELL_CYC - 1));
        refresh_hit = (refresh_cnt == RW'(REFRESH_CYC - 1));
        idx_change  = step_up | step_dn | dwell_hit;
    end

    // Viewed index, auto-scan flag and dwell timer; the 5-bit index wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            auto_mode <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            if (step_up) begin
                idx <= idx + 5'd1;
            end else if (step_dn) begin
                idx <= idx - 5'd1;
            end else if (dwell_hit) begin
                idx <= idx + 5'd1;
            end

            if (p_mode) begin
                auto_mode <= ~auto_mode;
                dwell_cnt <= '0;
            end else if (idx_change || !auto_mode) begin
                dwell_cnt <= '0;
            end else begin
                dwell_cnt <= dwell_cnt + DW'(1);
            end
        end
    end

    assign leds = idx;

    // Free-running refresh timer so the shown value tracks register updates
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
        end else if (refresh_hit) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    // Read/present sequencer; req coalesces every request raised while a read is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req        <= 1'b1;
            rf_raddr   <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        rf_raddr <= idx;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    state <= CAPT;
                end
                CAPT: begin
                    disp_data  <= rf_rdata;
                    disp_valid <= 1'b1;
                    state      <= PRES;
                end
                PRES: begin
                    if (disp_ready) begin
                        disp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (idx_change || refresh_hit) begin
                req <= 1'b1;
            end else if (state == IDLE && req) begin
                req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_view_ctrl.sv
// tb_reg_view_ctrl: randomized bench for reg_view_ctrl with a cycle-timed
// reference model and a scoreboard of expected display values.
module tb_reg_view_ctrl;

    localparam int DEB     = 8;
    localparam int DWELL   = 16;
    localparam int REFRESH = 97;

    localparam int K_R    = 0;
    localparam int K_L    = 1;
    localparam int K_MODE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_r = 1'b0;
    logic        btn_l = 1'b0;
    logic        btn_mode = 1'b0;
    logic        disp_ready = 1'b1;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [31:0] disp_data;
    logic        disp_valid;
    logic [4:0]  leds;
    logic        auto_mode;

    logic [31:0] rf_mem [32];

    typedef struct {
        int at;
        int kind;
    } ev_t;

    ev_t         sched [$];
    logic [31:0] exp_q [$];

    int tests = 0;
    int fails = 0;

    // Reference model state: cycles counted from the last reset edge
    int cyc = 0;
    int m_idx = 0;
    bit m_auto = 0;
    int m_dwell_start = 0;
    bit m_pending = 0;
    bit m_busy = 0;
    int m_present_from = 0;
    int m_launch_idx = 0;
    int m_raddr = 0;
    bit model_live = 0;
    bit rand_ready = 0;

    reg_view_ctrl #(
        .DEBOUNCE_CYC(DEB),
        .DWELL_CYC(DWELL),
        .REFRESH_CYC(REFRESH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_r(btn_r),
        .btn_l(btn_l),
        .btn_mode(btn_mode),
        .rf_raddr(rf_raddr),
        .rf_rdata(rf_rdata),
        .disp_data(disp_data),
        .disp_valid(disp_valid),
        .disp_ready(disp_ready),
        .leds(leds),
        .auto_mode(auto_mode)
    );

    assign rf_rdata = rf_mem[rf_raddr];

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance n cycles, leaving inputs to change 2 time units after each rising edge
    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            if (rand_ready) begin
                disp_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 15) == 0) begin
                    rf_mem[$urandom_range(0, 31)] = $urandom;
                end
            end
        end
    endtask

    // Hold one raw button high for 'hold' cycles, then leave it low long enough to settle.
    // A hold of at least DEB cycles is accepted and takes effect DEB+3 cycles after the rise.
    task automatic applyStimulus(input int kind, input int hold);
        ev_t e;
        if (hold >= DEB) begin
            e.at   = cyc + DEB + 3;
            e.kind = kind;
            sched.push_back(e);
        end
        case (kind)
            K_R:     btn_r = 1'b1;
            K_L:     btn_l = 1'b1;
            default: btn_mode = 1'b1;
        endcase
        waitCycles(hold);
        btn_r    = 1'b0;
        btn_l    = 1'b0;
        btn_mode = 1'b0;
        waitCycles(DEB + 6);
    endtask

    // Reference model: index rules, auto-scan timing, refresh timing and the 3-cycle read latency
    initial begin
        int up;
        int dn;
        int step;
        bit tog;
        bit served;
        forever begin
            @(posedge clk);
            if (rst) begin
                cyc           = 0;
                m_idx         = 0;
                m_auto        = 0;
                m_dwell_start = 0;
                m_pending     = 1;
                m_busy        = 0;
                m_raddr       = 0;
                exp_q.delete();
                sched.delete();
                model_live    = 1;
            end else if (model_live) begin
                cyc++;
                up  = 0;
                dn  = 0;
                tog = 0;
                for (int i = sched.size() - 1; i >= 0; i--) begin
                    if (sched[i].at == cyc) begin
                        case (sched[i].kind)
                            K_R:     up++;
                            K_L:     dn++;
                            default: tog = 1;
                        endcase
                        sched.delete(i);
                    end
                end

                served = 0;
                if (m_busy) begin
                    if (cyc == m_present_from - 1) begin
                        exp_q.push_back(rf_mem[m_launch_idx]);
                    end
                    if (cyc >= m_present_from && disp_ready) begin
                        m_busy = 0;
                    end
                end else if (m_pending) begin
                    served         = 1;
                    m_busy         = 1;
                    m_launch_idx   = m_idx;
                    m_raddr        = m_idx;
                    m_present_from = cyc + 3;
                end

                step = 0;
                if (up != dn) begin
                    step = up - dn;
                end else if (m_auto && (cyc - m_dwell_start == DWELL)) begin
                    step = 1;
                end
                if (step != 0) begin
                    m_idx         = (m_idx + step + 32) % 32;
                    m_dwell_start = cyc;
                end
                if (tog) begin
                    m_auto        = !m_auto;
                    m_dwell_start = cyc;
                end

                if (served) begin
                    m_pending = 0;
                end
                if (step != 0 || (cyc % REFRESH) == 0) begin
                    m_pending = 1;
                end
            end
        end
    end

    // Monitor: per-cycle state checks plus scoreboard pop on each accepted display transfer
    initial begin
        logic        prev_valid = 1'b0;
        logic        prev_ready = 1'b0;
        logic        prev_rst = 1'b1;
        logic [31:0] prev_data = '0;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (model_live) begin
                checkOutput("leds", {27'b0, leds}, 32'(m_idx));
                checkOutput("auto_mode", {31'b0, auto_mode}, {31'b0, m_auto});
                checkOutput("disp_valid", {31'b0, disp_valid},
                            {31'b0, (m_busy && cyc >= m_present_from - 1)});
                checkOutput("rf_raddr", {27'b0, rf_raddr}, 32'(m_raddr));
                if (prev_valid && !prev_ready && !prev_rst) begin
                    checkOutput("hold_valid", {31'b0, disp_valid}, 32'd1);
                    checkOutput("hold_data", disp_data, prev_data);
                end
                if (disp_valid && disp_ready && !rst) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_xfer", disp_data, 32'hFFFF_FFFF ^ disp_data);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("disp_data", disp_data, e);
                    end
                end
            end
            prev_valid = disp_valid;
            prev_ready = disp_ready;
            prev_rst   = rst;
            prev_data  = disp_data;
        end
    end

    // Watchdog so the run always ends
    initial begin
        #400000;
        fails++;
        $display("[TB] FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized phase
    initial begin
        int kind;
        int hold;
        int r;
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = $urandom;
        end
        rf_mem[0] = 32'hDEAD_BEEF;

        // Reset with r0 holding a known pattern
        rst        = 1'b1;
        disp_ready = 1'b1;
        waitCycles(3);
        rst = 1'b0;
        waitCycles(10);

        // Short glitch ignored, long hold gives exactly one step
        applyStimulus(K_R, 5);
        applyStimulus(K_R, 20);

        // Wrap around in both directions
        applyStimulus(K_L, 10);
        applyStimulus(K_L, 10);
        applyStimulus(K_R, 10);
        applyStimulus(K_L, 12);
        waitCycles(5);

        // Display stalled while stepping twice: value frozen, next read shows the latest index
        disp_ready = 1'b0;
        applyStimulus(K_R, 9);
        applyStimulus(K_R, 9);
        waitCycles(4);
        disp_ready = 1'b1;
        waitCycles(10);

        // Auto-scan with a manual step restarting the dwell
        applyStimulus(K_MODE, 10);
        waitCycles(40);
        applyStimulus(K_L, 10);
        waitCycles(30);
        applyStimulus(K_MODE, 10);

        // Reset while a value is being presented
        disp_ready = 1'b0;
        applyStimulus(K_R, 10);
        for (int k = 0; k < 120 && !disp_valid; k++) begin
            waitCycles(1);
        end
        checkOutput("pres_reached", {31'b0, disp_valid}, 32'd1);
        rst = 1'b1;
        waitCycles(1);
        rst        = 1'b0;
        disp_ready = 1'b1;
        waitCycles(10);

        // Randomized presses, glitches, stalls and register updates
        rand_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            r    = $urandom_range(0, 9);
            kind = (r < 4) ? K_R : ((r < 8) ? K_L : K_MODE);
            hold = $urandom_range(3, 16);
            applyStimulus(kind, hold);
            if ($urandom_range(0, 2) == 0) begin
                waitCycles($urandom_range(1, 40));
            end
        end
        rand_ready = 1'b0;
        disp_ready = 1'b1;
        waitCycles(30);
        @(negedge clk);
        #1;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
